// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
// Sequences two external dual-port line-buffer BRAMs (1-cycle registered
// read, read-first) to turn a raster pixel stream into 3-row columns
// (top = row y-2, mid = row y-1, bot = row y) for the 3x3 kernel stages.
// Optional feature: define LBC_SOF_EN to add the i_sof port, which forces
// the accepted pixel to column 0, row 0, buffer 0 (mid-frame resync allowed).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Input side: accept = i_valid && o_ready. Output side: the
// column is consumed when o_valid && i_out_ready. Once o_valid is high,
// every output holds stable until it is consumed.
module line_buffer_ctrl #(
    parameter int PIX_WIDTH  = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    // Derived widths; leave at their defaults.
    parameter int AW         = $clog2(IMG_WIDTH),
    parameter int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [PIX_WIDTH-1:0] i_pixel,
    output logic                 o_ready,
`ifdef LBC_SOF_EN
    input  logic                 i_sof,
`endif
    output logic [AW-1:0]        lb_addr,
    output logic [1:0]           lb_wr_en,
    output logic [PIX_WIDTH-1:0] lb_wr_data,
    output logic                 lb_rd_en,
    input  logic [PIX_WIDTH-1:0] lb0_rdata,
    input  logic [PIX_WIDTH-1:0] lb1_rdata,
    output logic                 o_valid,
    input  logic                 i_out_ready,
    output logic [PIX_WIDTH-1:0] o_top,
    output logic [PIX_WIDTH-1:0] o_mid,
    output logic [PIX_WIDTH-1:0] o_bot,
    output logic [AW-1:0]        o_col,
    output logic [RW-1:0]        o_row,
    output logic                 o_eol,
    output logic                 o_eof
);

    localparam logic [AW-1:0] COL_LAST = AW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Input position counters; wsel names the buffer holding row y-2.
    logic [AW-1:0] col;
    logic [RW-1:0] row;
    logic          wsel;

    // Position of the pixel being accepted this cycle (after any resync).
    logic [AW-1:0] col_eff;
    logic [RW-1:0] row_eff;
    logic          wsel_eff;
    logic          sof_hit;
    logic          at_eol;
    logic          at_eof;

    logic          accept;
    logic [AW-1:0] addr_q;

    // Stage-1 registers aligned with the BRAM read data.
    logic                 valid_q;
    logic                 wsel_d;
    logic [PIX_WIDTH-1:0] bot_q;
    logic [AW-1:0]        col_d;
    logic [RW-1:0]        row_d;
    logic                 eol_d;
    logic                 eof_d;

`ifdef LBC_SOF_EN
    assign sof_hit = i_sof;
`else
    assign sof_hit = 1'b0;
`endif

    // A stalled output blocks new input so the BRAM read registers hold.
    assign o_ready = !valid_q || i_out_ready;
    assign accept  = i_valid && o_ready;

    assign col_eff  = sof_hit ? '0   : col;
    assign row_eff  = sof_hit ? '0   : row;
    assign wsel_eff = sof_hit ? 1'b0 : wsel;
    assign at_eol   = (col_eff == COL_LAST);
    assign at_eof   = at_eol && (row_eff == ROW_LAST);

    // Write the incoming pixel over row y-2 while reading both buffers at
    // the same column; read-first returns row y-2 from the written buffer.
    assign lb_addr    = accept ? col_eff : addr_q;
    assign lb_rd_en   = accept;
    assign lb_wr_en   = {accept && wsel_eff, accept && !wsel_eff};
    assign lb_wr_data = i_pixel;

    // Advance column/row/buffer-select on every accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            wsel <= 1'b0;
        end else if (accept) begin
            if (at_eof) begin
                col  <= '0;
                row  <= '0;
                wsel <= 1'b0;
            end else if (at_eol) begin
                col  <= '0;
                row  <= row_eff + RW'(1);
                wsel <= !wsel_eff;
            end else begin
                col  <= col_eff + AW'(1);
                row  <= row_eff;
                wsel <= wsel_eff;
            end
        end
    end

    // Hold the last used BRAM address between accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= col_eff;
        end
    end

    // Capture the accepted pixel's data and position; rows 0 and 1 only fill the buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wsel_d  <= 1'b0;
            bot_q   <= '0;
            col_d   <= '0;
            row_d   <= '0;
            eol_d   <= 1'b0;
            eof_d   <= 1'b0;
        end else if (accept) begin
            valid_q <= (row_eff > RW'(1));
            wsel_d  <= wsel_eff;
            bot_q   <= i_pixel;
            col_d   <= col_eff;
            row_d   <= row_eff;
            eol_d   <= at_eol;
            eof_d   <= at_eof;
        end else if (i_out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Buffer data is qualified by o_valid so the outputs read zero out of reset.
    assign o_valid = valid_q;
    assign o_top   = valid_q ? (wsel_d ? lb1_rdata : lb0_rdata) : '0;
    assign o_mid   = valid_q ? (wsel_d ? lb0_rdata : lb1_rdata) : '0;
    assign o_bot   = bot_q;
    assign o_col   = col_d;
    assign o_row   = row_d;
    assign o_eol   = eol_d;
    assign o_eof   = eof_d;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl with a 4x4 image, pixel = row*16 + col.
// Optional feature: compiled with LBC_SOF_EN it also drives i_sof.
module tb_line_buffer_ctrl;

    localparam int PW = 12;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 2;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [PW-1:0] i_pixel;
    logic          o_ready;
`ifdef LBC_SOF_EN
    logic          i_sof;
    logic          sof_next;
`endif
    logic [AW-1:0] lb_addr;
    logic [1:0]    lb_wr_en;
    logic [PW-1:0] lb_wr_data;
    logic          lb_rd_en;
    logic [PW-1:0] lb0_rdata;
    logic [PW-1:0] lb1_rdata;
    logic          o_valid;
    logic          i_out_ready;
    logic [PW-1:0] o_top;
    logic [PW-1:0] o_mid;
    logic [PW-1:0] o_bot;
    logic [AW-1:0] o_col;
    logic [RW-1:0] o_row;
    logic          o_eol;
    logic          o_eof;

    logic [PW-1:0] mem0 [W];
    logic [PW-1:0] mem1 [W];

    logic [41:0] exp_q [$];
    int checks  = 0;
    int errors  = 0;
    int out_cnt = 0;

    line_buffer_ctrl #(.PIX_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_pixel(i_pixel), .o_ready(o_ready),
`ifdef LBC_SOF_EN
        .i_sof(i_sof),
`endif
        .lb_addr(lb_addr), .lb_wr_en(lb_wr_en), .lb_wr_data(lb_wr_data),
        .lb_rd_en(lb_rd_en), .lb0_rdata(lb0_rdata), .lb1_rdata(lb1_rdata),
        .o_valid(o_valid), .i_out_ready(i_out_ready), .o_top(o_top), .o_mid(o_mid),
        .o_bot(o_bot), .o_col(o_col), .o_row(o_row), .o_eol(o_eol), .o_eof(o_eof)
    );

    // Clock and stale buffer contents
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < W; i++) begin
            mem0[i] = 12'hABC;
            mem1[i] = 12'hDEF;
        end
    end

    // External BRAM pair: registered read, read-first on same-address write
    always @(posedge clk) begin
        if (lb_rd_en) begin
            lb0_rdata <= mem0[lb_addr];
            lb1_rdata <= mem1[lb_addr];
        end
        if (lb_wr_en[0]) mem0[lb_addr] <= lb_wr_data;
        if (lb_wr_en[1]) mem1[lb_addr] <= lb_wr_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected column for the pixel at (r, c), r >= 2
    function automatic logic [41:0] exp_of(input int r, input int c);
        logic [PW-1:0] t, m, b;
        t = PW'((r - 2) * 16 + c);
        m = PW'((r - 1) * 16 + c);
        b = PW'(r * 16 + c);
        return {t, m, b, AW'(c), RW'(r), (c == W - 1), (c == W - 1 && r == H - 1)};
    endfunction

    // Scoreboard monitor: pop and compare on each output handshake
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'({o_top, o_mid, o_bot}), 64'(0));
            end else if (i_out_ready) begin
                check("column", 64'({o_top, o_mid, o_bot, o_col, o_row, o_eol, o_eof}),
                      64'(exp_q.pop_front()));
                out_cnt++;
            end
        end
    end

    // Present one pixel, wait (bounded) for accept, check the BRAM port
    task automatic send_pixel(input int r, input int c);
        int waited = 0;
        i_valid = 1'b1;
        i_pixel = PW'(r * 16 + c);
`ifdef LBC_SOF_EN
        i_sof = sof_next;
`endif
        @(negedge clk);
        while (!o_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!o_ready) begin
            check("accept_timeout", 64'(o_ready), 64'(1));
        end else begin
            check("bram_port", 64'({lb_addr, lb_wr_en, lb_rd_en, lb_wr_data}),
                  64'({AW'(c), (r % 2 == 1) ? 2'b10 : 2'b01, 1'b1, PW'(r * 16 + c)}));
            if (r >= 2) exp_q.push_back(exp_of(r, c));
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
`ifdef LBC_SOF_EN
        i_sof    = 1'b0;
        sof_next = 1'b0;
`endif
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_port", 64'({lb_rd_en, lb_wr_en}), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit bubbles);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pixel(r, c);
                if (bubbles) idle_cycle();
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_pixel     = '0;
        i_out_ready = 1'b1;
`ifdef LBC_SOF_EN
        i_sof       = 1'b0;
        sof_next    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              64'({o_valid, o_ready, o_top, o_mid, o_bot, o_col, o_row, o_eol, o_eof, lb_rd_en, lb_wr_en}),
              64'({1'b0, 1'b1, 36'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00}));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two back-to-back frames at full rate
        out_cnt = 0;
        send_frame(1'b0);
        send_frame(1'b0);
        drain();
        check("frames_ab_count", 64'(out_cnt), 64'(16));

        // Frame with an idle cycle after every pixel
        out_cnt = 0;
        send_frame(1'b1);
        drain();
        check("bubble_count", 64'(out_cnt), 64'(8));

        // Backpressure while (0x01, 0x11, 0x21) is presented
        out_cnt = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) send_pixel(r, c);
        send_pixel(2, 0);
        send_pixel(2, 1);
        i_out_ready = 1'b0;
        i_valid     = 1'b1;
        i_pixel     = 12'h022;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold",
                  64'({o_valid, o_ready, lb_rd_en, lb_wr_en, o_top, o_mid, o_bot}),
                  64'({1'b1, 1'b0, 1'b0, 2'b00, 12'h001, 12'h011, 12'h021}));
        end
        @(posedge clk);
        #1;
        i_out_ready = 1'b1;
        send_pixel(2, 2);
        send_pixel(2, 3);
        for (int c = 0; c < W; c++) send_pixel(3, c);
        drain();
        check("backpressure_count", 64'(out_cnt), 64'(8));

        // Asynchronous reset while a row-2 column is held
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) send_pixel(r, c);
        send_pixel(2, 0);
        i_out_ready = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", 64'(o_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset",
              64'({o_valid, o_top, o_mid, o_bot, o_col, o_row, o_eol, o_eof}),
              64'(0));
        exp_q.delete();
        @(negedge clk);
        rst         = 1'b0;
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_cnt = 0;
        send_frame(1'b0);
        drain();
        check("post_reset_count", 64'(out_cnt), 64'(8));

`ifdef LBC_SOF_EN
        // Resync mid-row: pixel at (1,2) carries i_sof and becomes (0,0)
        out_cnt = 0;
        for (int c = 0; c < W; c++) send_pixel(0, c);
        send_pixel(1, 0);
        send_pixel(1, 1);
        sof_next = 1'b1;
        send_pixel(0, 0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r != 0 || c != 0) send_pixel(r, c);
        drain();
        check("sof_count", 64'(out_cnt), 64'(8));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
